// File: rtl/mem_bus_arbiter.sv
// Three-port round-robin arbiter in front of the single-port video/work memory.
// The grant is registered. Each grant lasts for a bounded burst, and read data returns one cycle after the access.
module mem_bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int BURST_MAX = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [2:0]      REQ,
  input  logic [2:0]      WR,
  input  logic [3*AW-1:0] ADDR,
  input  logic [3*DW-1:0] WDATA,
  output logic [2:0]      GNT,
  output logic [DW-1:0]   RDATA,
  output logic [2:0]      RVALID,
  output logic [1:0]      OWNER,
  output logic            MEM_ENABLE,
  output logic            MEM_WRITE,
  output logic [AW-1:0]   MEM_ADDR,
  output logic [DW-1:0]   MEM_DATA_W,
  input  logic [DW-1:0]   MEM_DATA_R
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  burst_q, burst_d;
  logic [2:0]  rtag_q, rtag_d;

  logic        acc, acc_wr;
  logic        win_found, rel;
  logic [1:0]  win, cand;

  // Access mux: the granted port drives the memory in the same cycle.
  always_comb begin
    acc        = 1'b0;
    acc_wr     = 1'b0;
    MEM_ADDR   = '0;
    MEM_DATA_W = '0;
    for (int k = 0; k < 3; k++) begin
      if (gnt_q[k] && REQ[k]) begin
        acc        = 1'b1;
        acc_wr     = WR[k];
        MEM_ADDR   = ADDR[k*AW +: AW];
        MEM_DATA_W = WDATA[k*DW +: DW];
      end
    end
    MEM_ENABLE = acc;
    MEM_WRITE  = acc_wr;
  end

  always_comb begin
    win_found = 1'b0;
    win       = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      cand = 2'((int'(last_q) + i) % 3);
      if (!win_found && REQ[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end

    // The >= comparison lets a saturated count from a solo stream yield as soon as a rival appears.
    rel = (state_q == S_IDLE) || !(|(REQ & gnt_q)) ||
          ((burst_q >= 8'(BURST_MAX - 1)) && |(REQ & ~gnt_q));

    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    rtag_d  = (acc && !acc_wr) ? gnt_q : 3'b000;

    if (rel) begin
      burst_d = 8'd0;
      if (win_found) begin
        state_d = S_OWN;
        gnt_d   = 3'b001 << win;
        owner_d = win;
        last_d  = win;
      end else begin
        state_d = S_IDLE;
        gnt_d   = 3'b000;
        owner_d = 2'd3;
      end
    end else if (acc && burst_q != 8'hFF) begin
      burst_d = burst_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      gnt_q   <= 3'b000;
      owner_q <= 2'd3;
      last_q  <= 2'd2;
      burst_q <= 8'd0;
      rtag_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rtag_q  <= rtag_d;
    end
  end

  assign GNT    = gnt_q;
  assign OWNER  = owner_q;
  assign RVALID = rtag_q;
  assign RDATA  = (|rtag_q) ? MEM_DATA_R : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter.
// A transaction-level model of grants, bursts and read returns supplies the expected values.
module tb_mem_bus_arbiter;
  localparam int AW = 16, DW = 16, BM = 16;

  logic          CLK = 1'b0, RESET = 1'b1;
  logic [2:0]    REQ = '0, WR = '0;
  logic [3*AW-1:0] ADDR = '0;
  logic [3*DW-1:0] WDATA = '0;
  logic [2:0]    GNT, RVALID;
  logic [DW-1:0] RDATA, MEM_DATA_R;
  logic [1:0]    OWNER;
  logic          MEM_ENABLE, MEM_WRITE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_DATA_W;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WR(WR), .ADDR(ADDR), .WDATA(WDATA),
    .GNT(GNT), .RDATA(RDATA), .RVALID(RVALID), .OWNER(OWNER),
    .MEM_ENABLE(MEM_ENABLE), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_W(MEM_DATA_W), .MEM_DATA_R(MEM_DATA_R));

  always #5 CLK = ~CLK;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a, ~a} ^ 16'h5a5a;
  endfunction

  // Memory seen by the DUT: one-cycle read latency, indexed by the low address byte.
  logic [15:0] dmem [256];
  logic        dval [256];
  always @(posedge CLK) begin
    if (MEM_ENABLE) begin
      if (MEM_WRITE) begin
        dmem[MEM_ADDR[7:0]] <= MEM_DATA_W;
        dval[MEM_ADDR[7:0]] <= 1'b1;
      end else begin
        MEM_DATA_R <= (dval[MEM_ADDR[7:0]] === 1'b1) ? dmem[MEM_ADDR[7:0]] : init_val(MEM_ADDR[7:0]);
      end
    end
  end

  int nvec = 0, nerr = 0;
  bit checking = 0;
  logic [15:0] ref_mem [256];
  int m_own = 3, m_last = 2, m_cnt = 0;
  logic [2:0]  m_ptag = '0;
  logic [15:0] m_pdata = '0;
  logic [2:0]  s_gnt, s_rv;
  logic [1:0]  s_owner;
  logic        s_en;
  logic [15:0] s_addr, s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input logic [2:0] req, input logic [2:0] wr,
                      input logic [3*AW-1:0] addr, input logic [3*DW-1:0] wd);
    logic [2:0] e_gnt, nptag, others;
    logic acc, rearb;
    logic [15:0] a, d;
    int w;
    @(negedge CLK);
    RESET = rst; REQ = req; WR = wr; ADDR = addr; WDATA = wd;
    #1;
    s_gnt = GNT; s_rv = RVALID; s_owner = OWNER; s_en = MEM_ENABLE; s_addr = MEM_ADDR; s_rd = RDATA;
    e_gnt = (m_own < 3) ? 3'(1 << m_own) : 3'b000;
    acc   = (m_own < 3) && req[m_own];
    a     = acc ? addr[m_own*AW +: AW] : 16'h0;
    d     = acc ? wd[m_own*DW +: DW] : 16'h0;
    if (checking) begin
      chk("gnt", 32'(GNT), 32'(e_gnt));
      chk("owner", 32'(OWNER), 32'(m_own));
      chk("mem_en", 32'(MEM_ENABLE), 32'(acc));
      chk("mem_wr", 32'(MEM_WRITE), 32'(acc && wr[m_own]));
      chk("mem_addr", 32'(MEM_ADDR), 32'(a));
      chk("mem_wdata", 32'(MEM_DATA_W), 32'(d));
      chk("rvalid", 32'(RVALID), 32'(m_ptag));
      if (m_ptag != 0) chk("rdata", 32'(RDATA), 32'(m_pdata));
    end
    nptag = '0;
    if (acc) begin
      if (wr[m_own]) ref_mem[a[7:0]] = d;
      else begin nptag = 3'(1 << m_own); m_pdata = ref_mem[a[7:0]]; end
    end
    others = req & ~e_gnt;
    rearb = (m_own == 3) || !req[m_own] || (m_cnt >= BM - 1 && others != 0);
    if (rearb) begin
      w = -1;
      for (int i = 1; i <= 3; i++)
        if (w < 0 && req[(m_last + i) % 3]) w = (m_last + i) % 3;
      if (w >= 0) begin m_own = w; m_last = w; end
      else m_own = 3;
      m_cnt = 0;
    end else if (acc) begin
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    m_ptag = nptag;
    if (rst) begin m_own = 3; m_last = 2; m_cnt = 0; m_ptag = '0; end
    @(posedge CLK);
  endtask

  task automatic do_reset();
    step(1, 3'b000, 3'b000, '0, '0);
    step(0, 3'b000, 3'b000, '0, '0);
  endtask

  initial begin
    logic [2:0] rq, wrr;
    logic [3*AW-1:0] ad;
    logic [3*DW-1:0] wdt;
    int n_g, n_rv;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

    step(1, 3'b000, 3'b000, '0, '0);
    checking = 1;
    step(1, 3'b000, 3'b000, '0, '0);
    step(0, 3'b000, 3'b000, '0, '0);
    chk("reset_gnt", 32'(s_gnt), 32'h0);
    chk("reset_owner", 32'(s_owner), 32'h3);
    chk("reset_rdata", 32'(s_rd), 32'h0);

    // Single read by port 0.
    ad = {16'h0, 16'h0, 16'h0010};
    step(0, 3'b001, 3'b000, ad, '0);
    step(0, 3'b001, 3'b000, ad, '0);
    chk("p0_gnt", 32'(s_gnt), 32'h1);
    chk("p0_en", 32'(s_en), 32'h1);
    chk("p0_addr", 32'(s_addr), 32'h0010);
    step(0, 3'b000, 3'b000, ad, '0);
    chk("p0_rvalid", 32'(s_rv), 32'h1);
    chk("p0_rdata", 32'(s_rd), 32'(init_val(8'h10)));

    // All three request: bursts of 16, order 0,1,2,0.
    do_reset();
    for (int c = 0; c <= 50; c++) begin
      ad = {16'(c + 2), 16'(c + 1), 16'(c)};
      step(0, 3'b111, 3'b000, ad, '0);
      if (c == 1 || c == 16)  chk("rr_own0", 32'(s_owner), 32'h0);
      if (c == 17 || c == 32) chk("rr_own1", 32'(s_owner), 32'h1);
      if (c == 33 || c == 48) chk("rr_own2", 32'(s_owner), 32'h2);
      if (c == 49) chk("rr_own0_again", 32'(s_owner), 32'h0);
      if (c >= 1) chk("rr_no_dead", 32'(s_en), 32'h1);
    end

    // Port 2 streams 40 reads alone.
    do_reset();
    n_g = 0; n_rv = 0;
    for (int c = 0; c <= 41; c++) begin
      ad = {16'(8'(c * 3)), 16'h0, 16'h0};
      step(0, (c <= 40) ? 3'b100 : 3'b000, 3'b000, ad, '0);
      if (c >= 1 && c <= 40 && s_gnt == 3'b100 && s_en) n_g++;
      if (s_rv == 3'b100) n_rv++;
    end
    chk("p2_stream_gnt", 32'(n_g), 32'd40);
    chk("p2_stream_rv", 32'(n_rv), 32'd40);

    // Owner drops REQ while port 1 waits: one dead cycle.
    do_reset();
    step(0, 3'b011, 3'b000, '0, '0);
    step(0, 3'b011, 3'b000, '0, '0);
    step(0, 3'b010, 3'b000, '0, '0);
    chk("drop_en", 32'(s_en), 32'h0);
    step(0, 3'b010, 3'b000, '0, '0);
    chk("drop_gnt", 32'(s_gnt), 32'h2);

    // Last-beat read by port 1 returns while port 2 issues its first access.
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      ad = {16'h0044, 16'(8'h20 + c), 16'h0};
      step(0, 3'b110, 3'b000, ad, '0);
    end
    chk("handoff_rv", 32'(s_rv), 32'h2);
    chk("handoff_gnt", 32'(s_gnt), 32'h4);
    chk("handoff_en", 32'(s_en), 32'h1);

    // Reset in the middle of a read burst.
    do_reset();
    for (int c = 0; c < 5; c++) step(0, 3'b001, 3'b000, {32'h0, 16'(c)}, '0);
    step(1, 3'b001, 3'b000, {32'h0, 16'h0007}, '0);
    step(0, 3'b000, 3'b000, '0, '0);
    chk("mrst_gnt", 32'(s_gnt), 32'h0);
    chk("mrst_rv", 32'(s_rv), 32'h0);
    chk("mrst_en", 32'(s_en), 32'h0);
    step(0, 3'b110, 3'b000, '0, '0);
    step(0, 3'b110, 3'b000, '0, '0);
    chk("mrst_first", 32'(s_gnt), 32'h2);

    // Randomized traffic with sticky requests, mixed reads/writes, rare resets.
    rq = 3'b000;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 3; k++) if ($urandom_range(7) == 0) rq[k] = ~rq[k];
      wrr = 3'($urandom);
      ad  = {16'(8'($urandom)), 16'(8'($urandom)), 16'(8'($urandom))};
      wdt = {16'($urandom), 16'($urandom), 16'($urandom)};
      step(($urandom_range(499) == 0), rq, wrr, ad, wdt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port 16-bit video/work memory between three requesters: port 0 = game processor, port 1 = system processor, port 2 = GPU framebuffer reader.
- Registered round-robin grant with a bounded burst length, so no requester can starve another.
- Read data is returned with a per-port valid pulse.
- Sits between the requesters and the memory controller; it is the sole driver of the memory controller's MEM_* inputs.

Parameters:
- AW, 16, address width per port
- DW, 16, data width per port
- BURST_MAX, 16, maximum consecutive accesses per grant while another port is requesting (legal range 1..255)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- REQ  in  3  per-port request; bit k = port k; held high for as long as port k wants the bus
- WR  in  3  per-port write strobe (1 = write, 0 = read); sampled only while granted
- ADDR  in  3*AW  per-port address; port k at [k*AW +: AW]
- WDATA  in  3*DW  per-port write data; port k at [k*DW +: DW]
- GNT  out  3  one-hot grant (registered)
- RDATA  out  DW  read data, shared by all ports
- RVALID  out  3  one-cycle pulse; bit k marks RDATA as valid for port k
- OWNER  out  2  index of the current owner (3 = none)
- MEM_ENABLE  out  1  memory access strobe
- MEM_WRITE  out  1  memory write select
- MEM_ADDR  out  AW  memory address
- MEM_DATA_W  out  DW  memory write data
- MEM_DATA_R  in  DW  memory read data, valid 1 cycle after a read access

Behaviour:
- FSM states: IDLE (GNT=0, OWNER=3) and OWN (GNT one-hot, OWNER=k).
- Reset values: GNT=0, OWNER=3, RVALID=0, MEM_ENABLE=0, MEM_WRITE=0, MEM_ADDR=0, MEM_DATA_W=0, RDATA=0.
  - Internal state on reset: burst count=0, last-winner pointer=2, read-tag cleared.
  - An access in flight is abandoned: its RVALID is suppressed.
- Arbitration happens at every clock edge where the state is IDLE, or OWN with a release condition.
  - Winner = first requesting port scanning from last+1 modulo 3.
  - GNT updates at the edge; last = winner; burst count = 0.
  - Grant latency from REQ rising on an idle bus is 1 cycle.
- Access rule: in any cycle where GNT[k]=1 and REQ[k]=1, exactly one access occurs.
  - MEM_ENABLE=1; MEM_WRITE, MEM_ADDR and MEM_DATA_W are combinationally muxed from WR[k], ADDR slice k and WDATA slice k.
  - Otherwise MEM_ENABLE=0, MEM_WRITE=0, and address/data are held at 0.
  - Each access increments the burst count (saturating at 255).
- Release conditions, evaluated each cycle in OWN:
  - (a) REQ[k]=0: no access this cycle; rearbitrate at the edge. If no one is requesting, go to IDLE.
  - (b) An access completes with burst count = BURST_MAX-1 while another port is requesting: the access completes, then the grant moves at the edge to the next requester in round-robin order. The old owner gets no access in the following cycle.
  - If the owner is the only requester, the burst is unbounded and the count saturates with no effect.
- Handoff cost: 1 dead cycle under (a); 0 dead cycles under (b).
- Read return: a read access in cycle t produces RDATA=MEM_DATA_R and RVALID[k]=1 in cycle t+1.
  - This holds even if the grant changed at the t/t+1 edge.
  - The read-tag is registered with the access.
  - Write accesses never assert RVALID.
- Invariants: GNT is always 0 or one-hot; at most one RVALID bit is set per cycle.
- A requester changing WR or ADDR while granted takes effect in the same cycle, with no pipelining.

Test Plan:
- Reset, then REQ=3'b001 with read at ADDR0=0x0010 -> GNT=001 one cycle later, MEM_ENABLE=1 with MEM_ADDR=0x0010, RVALID=001 the following cycle with RDATA = memory contents.
- REQ=3'b111 raised in the same cycle after reset -> grant order is port 0, 1, 2, 0 (last pointer resets to 2). Each port gets exactly 16 accesses before rotating, with zero dead cycles between bursts.
- Port 2 alone streams 40 reads -> GNT stays 100 for all 40 accesses. 40 RVALID[2] pulses, each exactly 1 cycle after its access.
- Port 0 holds the grant and drops REQ at cycle t while port 1 is requesting -> MEM_ENABLE=0 at t, GNT=010 at t+1.
- Read by port 1 on the last burst beat, with the grant moving to port 2 -> RVALID=010 in the cycle port 2's first access is issued.
- Assert RESET mid-burst on a read -> next cycle GNT=0, RVALID=0, MEM_ENABLE=0. After release, REQ=3'b110 grants port 1 first.
